// File: rtl/filter_out_decim.sv
// rtl/filter_out_decim.sv - block-average decimator with FWFT output FIFO
//
// Purpose:
//   Sits downstream of the 16-bit filter. It sums each block of
//   2^DECIM_LOG2 enabled Yn samples and divides the sum by the block size.
//   The result goes into a small first-word-fall-through FIFO, which lets a
//   consumer stall without ever back-pressuring the filter. When a block
//   completes while the FIFO is full and nothing is popped on the same edge,
//   the result is dropped and the sticky overflow flag is raised.
//
// Configuration:
//   DECIM_ROUND_EN - when defined, results are rounded half-up instead of
//                    truncated. Latency and handshake are the same in both
//                    builds.
//
// Parameters:
//   DECIM_LOG2 - log2 of the decimation factor (1..6)
//   FIFO_AW    - log2 of the FIFO depth
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   Yn         in   [15:0] unsigned filter sample
//   in_en      in   Yn is valid this cycle
//   out_data   out  [15:0] FIFO head word (0 when empty)
//   out_valid  out  FIFO not empty
//   out_ready  in   consumer takes out_data this cycle
//   fifo_count out  [FIFO_AW:0] words stored
//   overflow   out  sticky, a block result was dropped

module filter_out_decim #(
  parameter int DECIM_LOG2 = 2,
  parameter int FIFO_AW    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        Yn,
  input  logic               in_en,
  output logic [15:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  localparam int AW    = 16 + DECIM_LOG2;
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [DECIM_LOG2-1:0] CNT_LAST   = '1;
  localparam logic [FIFO_AW:0]      COUNT_FULL = (FIFO_AW+1)'(DEPTH);

  // Decimator state
  logic [AW-1:0]         acc_q, acc_d;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;

  // FIFO state
  logic [15:0]           mem_q [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;

  // Datapath / control
  logic [AW-1:0]         sum;
  logic [15:0]           result;
  logic                  blk_done;
  logic                  full;
  logic                  pop;
  logic                  wr_en;

  // ---------------------------------------------------------------------------
  // Accumulator and block counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // The accumulator is DECIM_LOG2 bits wider than a sample, so summing a
    // whole block of 0xFFFF cannot wrap.
    sum      = acc_q + {{DECIM_LOG2{1'b0}}, Yn};
    blk_done = in_en && (cnt_q == CNT_LAST);

`ifdef DECIM_ROUND_EN
    // (sum + 2^(k-1)) >> k equals (sum >> k) plus the bit just below the cut.
    // The largest block sum still rounds to at most 0xFFFF, so the 16-bit
    // add cannot carry out.
    result = sum[AW-1:DECIM_LOG2] + {15'd0, sum[DECIM_LOG2-1]};
`else
    result = sum[AW-1:DECIM_LOG2];
`endif

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (in_en) begin
      if (blk_done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + DECIM_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT FIFO
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = (count_q != '0);
    full      = (count_q == COUNT_FULL);
    pop       = out_valid && out_ready;
    // When full, a pop on the same edge frees the slot the new word uses.
    wr_en     = blk_done && (!full || pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end

    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase

    if (blk_done && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage has no reset; the pointers and count define which words are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= result;
    end
  end

  // Head word is read straight from storage; forced to zero when empty so
  // the output is clean out of reset.
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : 16'd0;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/filter_out_decim.md
Name: filter_out_decim

Overview:
- Downstream stage of the 16-bit filter. Consumes the filter's Yn stream, one sample per enabled clock.
- Averages each block of 2^DECIM_LOG2 consecutive samples into one output word.
- Buffers the averaged words in a small first-word-fall-through FIFO with a valid/ready handshake to the next consumer.
- Decouples the filter's fixed sample rate from a consumer that can stall.

Parameters:
- DECIM_LOG2, 2, log2 of the decimation factor; DECIM = 2^DECIM_LOG2; legal range 1..6.
- FIFO_AW, 2, log2 of the FIFO depth; depth = 2^FIFO_AW entries.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- Yn  input  16  unsigned filter output sample.
- in_en  input  1  Yn is a valid sample this cycle; tie high for one sample per clock.
- out_data  output  16  averaged word at the FIFO head.
- out_valid  output  1  FIFO is not empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- fifo_count  output  FIFO_AW+1  number of words currently stored.
- overflow  output  1  sticky flag: a block result was dropped.

Behaviour:
- Reset, asynchronous and active-high:
  - accumulator = 0, sample counter = 0.
  - FIFO pointers = 0, fifo_count = 0.
  - out_valid = 0, out_data = 0, overflow = 0.
  - A reset mid-block discards the partial sum; counting restarts at sample 0.
- Accumulator width is 16+DECIM_LOG2 bits. No overflow is possible.
- On a clock with in_en=1 and cnt < DECIM-1: acc <= acc + Yn, cnt <= cnt + 1.
- On a clock with in_en=1 and cnt == DECIM-1:
  - result = (acc + Yn) >> DECIM_LOG2, truncating.
  - Push result into the FIFO.
  - acc <= 0, cnt <= 0.
- On a clock with in_en=0: acc and cnt hold.
- Latency: the result is at out_data with out_valid=1 in the cycle after the edge that captured the DECIM-th sample, when the FIFO was empty.
- FIFO is first-word-fall-through:
  - out_data is the head word and is driven combinationally from storage.
  - out_data is stable while out_valid=1 and out_ready=0.
- Pop occurs on an edge where out_valid=1 and out_ready=1. out_ready while empty has no effect.
- Push when not full: the word is written and fifo_count increments.
- Simultaneous push and pop:
  - fifo_count is unchanged and both operations take place.
  - This applies when full: the freed slot accepts the new word, and overflow is not set.
- Push when full without a pop: the word is dropped, FIFO contents are unchanged, and overflow <= 1.
- overflow stays set until reset.
- Pointers wrap modulo depth. fifo_count ranges 0..2^FIFO_AW.
- The accumulator continues regardless of FIFO state; a stalled consumer never back-pressures the filter.

Optional Feature:
- Macro: DECIM_ROUND_EN.
- Defined: result = (acc + Yn + 2^(DECIM_LOG2-1)) >> DECIM_LOG2, i.e. round-half-up.
  - The maximum result is still 0xFFFF, so no saturation logic is needed.
  - The accumulator width is unchanged.
- Undefined: truncation as described in Behaviour.
- Latency and handshake are identical in both builds.

Test Plan:
- DECIM_LOG2=2, in_en=1, out_ready=1, Yn = 1,2,3,4,5,6,7,8.
  - Truncate build: out_data=2, then 6.
  - DECIM_ROUND_EN build: out_data=3, then 7.
  - Each out_valid is a single-cycle pulse, one cycle after the 4th and 8th sample edges.
- Yn = 0xFFFF for 4 samples -> out_data=0xFFFF in both builds, with no wrap.
- out_ready=0 with 5 complete blocks of constant value 10 -> fifo_count=4 and overflow=1 after the 5th block.
  - Then set out_ready=1: four words of 10 drain, then out_valid=0.
  - overflow remains 1.
- FIFO full, and the next block completes on the same edge as a pop -> fifo_count stays 4, overflow stays 0, and the new word appears last in drain order.
- Yn=9,9, then assert reset for one cycle mid-block, then Yn=4,4,4,4 -> single output of 4.
  - out_valid=0 and fifo_count=0 during reset.
- in_en toggled 1,0,1,0,... with Yn=8 held -> one output of 8 after 4 enabled samples (7 clocks).
  - acc holds on the in_en=0 cycles.
